// File: rtl/piso_tx_4b_pkg.sv
// Shared types and constants for the 4-bit PISO transmitter.
// PISO_TX_4B_PARITY_EN adds a fifth, even-parity beat after data bit 3.
package piso_tx_4b_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned NDATA = 4;
`ifdef PISO_TX_4B_PARITY_EN
    localparam int unsigned NBEATS = 5;
`else
    localparam int unsigned NBEATS = 4;
`endif

    // Wide enough to hold the parity beat index (4).
    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(NDATA);

endpackage

// File: rtl/beat_counter.sv
// Beat index counter for the PISO transmitter; clear wins over increment.
module beat_counter
    import piso_tx_4b_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart on clear, step on a transferred beat.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/piso_tx_4b.sv
// 4-bit parallel-in serial-out transmitter, LSB first, valid/ready on both sides.
// PISO_TX_4B_PARITY_EN appends an even-parity beat after data bit 3.
module piso_tx_4b
    import piso_tx_4b_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NDATA-1:0] in_data,
    output logic             tx_val,
    input  logic             tx_rdy,
    output logic             tx_bit,
    output logic             tx_last
);

    state_e           state_q, state_d;
    logic [NDATA-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic             cnt_incr;
    logic             accept;
    logic             xfer;
    logic             data_bit;

`ifdef PISO_TX_4B_PARITY_EN
    logic parity_q, parity_d;
    assign data_bit = (cnt == PAR_IDX) ? parity_q : shreg_q[0];
`else
    assign data_bit = shreg_q[0];
`endif

    // Handshake outputs; in_rdy reopens on the final beat so words chain without a bubble.
    always_comb begin
        in_rdy  = 1'b1;
        tx_val  = 1'b0;
        tx_bit  = 1'b0;
        tx_last = 1'b0;
        if (state_q == SHIFT) begin
            tx_val  = 1'b1;
            tx_bit  = data_bit;
            tx_last = (cnt == LAST_IDX);
            in_rdy  = tx_last && tx_rdy;
        end
    end

    assign accept = in_val && in_rdy;
    assign xfer   = tx_val && tx_rdy;

    // Next-state: load on accept, otherwise shift out one bit per transferred beat.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
`ifdef PISO_TX_4B_PARITY_EN
        parity_d  = parity_q;
`endif
        if (accept) begin
            shreg_d   = in_data;
            cnt_clear = 1'b1;
            state_d   = SHIFT;
`ifdef PISO_TX_4B_PARITY_EN
            parity_d  = ^in_data;
`endif
        end else if (xfer) begin
            shreg_d  = {1'b0, shreg_q[NDATA-1:1]};
            cnt_incr = 1'b1;
            if (tx_last) begin
                state_d = IDLE;
            end
        end
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
`ifdef PISO_TX_4B_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
`ifdef PISO_TX_4B_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    beat_counter u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .count (cnt)
    );

endmodule

// File: tb/tb_piso_tx_4b.sv
// Scoreboard bench for piso_tx_4b: expected beats are queued on each accepted
// word and popped on each transferred beat. Honours PISO_TX_4B_PARITY_EN.
module tb_piso_tx_4b;

`ifdef PISO_TX_4B_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct packed {
        logic val;
        logic last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_data;
    logic       tx_val;
    logic       tx_rdy;
    logic       tx_bit;
    logic       tx_last;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    piso_tx_4b dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .tx_val  (tx_val),
        .tx_rdy  (tx_rdy),
        .tx_bit  (tx_bit),
        .tx_last (tx_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected serial beats for one word: LSB first, optional parity, last flag on final beat.
    task automatic push_word(input logic [3:0] d);
        for (int i = 0; i < NB; i++) begin
            beat_t b;
            b.val  = (i < 4) ? d[i] : ^d;
            b.last = (i == NB - 1);
            exp_q.push_back(b);
        end
    endtask

    // One clock: score at negedge, then return just after the next posedge.
    task automatic cycle();
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (tx_val && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'(tx_bit), 32'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("tx_bit", 32'(tx_bit), 32'(e.val));
                    check_eq("tx_last", 32'(tx_last), 32'(e.last));
                end
            end
            if (in_val && in_rdy) push_word(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
        check_eq({tag, "_tx_val"}, 32'(tx_val), 32'd0);
        check_eq({tag, "_tx_bit"}, 32'(tx_bit), 32'd0);
        check_eq({tag, "_tx_last"}, 32'(tx_last), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        in_val  = 1'b0;
        in_data = 4'h0;
        tx_rdy  = 1'b1;

        // Reset for two cycles.
        cycle();
        cycle();
        reset = 1'b0;
        check_idle("reset");

        // Single word 1011, one-cycle first-beat latency.
        in_val  = 1'b1;
        in_data = 4'b1011;
        cycle();
        in_val = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check_eq("single_tx_val", 32'(tx_val), 32'd1);
            if (i == NB - 1) check_eq("single_in_rdy_last", 32'(in_rdy), 32'd1);
            else             check_eq("single_in_rdy_mid", 32'(in_rdy), 32'd0);
            cycle();
        end
        check_idle("single_after");

        // Backpressure on the second beat; in_val during stall must be ignored.
        in_val  = 1'b1;
        in_data = 4'b0110;
        cycle();
        in_val = 1'b0;
        cycle();
        tx_rdy  = 1'b0;
        in_val  = 1'b1;
        in_data = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_tx_val", 32'(tx_val), 32'd1);
            check_eq("stall_tx_bit", 32'(tx_bit), 32'd1);
            check_eq("stall_in_rdy", 32'(in_rdy), 32'd0);
            cycle();
        end
        in_val = 1'b0;
        tx_rdy = 1'b1;
        for (int i = 1; i < NB; i++) cycle();
        check_idle("stall_after");

        // Back-to-back A then 5 with in_val held: no bubble.
        in_val  = 1'b1;
        in_data = 4'hA;
        cycle();
        in_data = 4'h5;
        for (int i = 0; i < 2 * NB; i++) begin
            check_eq("b2b_tx_val", 32'(tx_val), 32'd1);
            if (i == NB - 1) check_eq("b2b_in_rdy", 32'(in_rdy), 32'd1);
            cycle();
            if (i == NB - 1) in_val = 1'b0;
        end
        check_idle("b2b_after");

        // Reset after two beats of F; a following word 1 must start clean.
        in_val  = 1'b1;
        in_data = 4'hF;
        cycle();
        in_val = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_idle("midreset");
        in_val  = 1'b1;
        in_data = 4'h1;
        cycle();
        in_val = 1'b0;
        for (int i = 0; i < NB; i++) cycle();
        check_idle("midreset_after");

        // Word 0111 (exercises the parity beat when enabled).
        in_val  = 1'b1;
        in_data = 4'b0111;
        cycle();
        in_val = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check_eq("par_tx_last", 32'(tx_last), 32'(i == NB - 1));
            cycle();
        end
        check_idle("par_after");

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
